// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-granular round-robin share of one uart_transmitter.
// Optional accept timeout is built when TX_ARB_TIMEOUT_EN is defined.
//
// Ports:
//   clk, reset       system clock, synchronous active-high reset
//   req_valid/ready  per-requester byte handshake (ready is a 1-cycle pulse)
//   req_data         packed request bytes, byte i at [8i+7:8i]
//   req_last         offered byte closes its packet
//   grant            one-hot owner, 0 when unowned
//   tx_data/tx_send  byte and 1-cycle send pulse to the transmitter
//   tx_busy          transmitter busy
//   tx_err           1-cycle pulse when the transmitter never acknowledged
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic [7:0]           tx_data,
  output logic                 tx_send,
  input  logic                 tx_busy,
  output logic                 tx_err
);

  localparam int IW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
    $error("uart_tx_arbiter: unsupported parameters");
  end

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_ACK,
    WAIT_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [IW-1:0]        rr_q, rr_d;
  logic                 last_q, last_d;
  logic [NUM_REQ-1:0]   ready_q, ready_d;
  logic [7:0]           data_q, data_d;
  logic                 send_q, send_d;
  logic                 err_q, err_d;

`ifdef TX_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  logic [CW-1:0]        cnt_q, cnt_d;
`endif

  logic [IW-1:0]        own;
  logic [IW-1:0]        pick;
  logic [IW-1:0]        nxt_rr;

  // First valid requester scanning from p upward, wrapping at NUM_REQ.
  function automatic logic [IW-1:0] rr_pick(
    input logic [NUM_REQ-1:0] v,
    input logic [IW-1:0]      p
  );
    logic [IW-1:0] r;
    logic [IW:0]   s;
    logic          f;
    r = '0;
    f = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      s = {1'b0, p} + (IW+1)'(k);
      if (s >= (IW+1)'(NUM_REQ)) begin
        s = s - (IW+1)'(NUM_REQ);
      end
      if (!f && v[s[IW-1:0]]) begin
        f = 1'b1;
        r = s[IW-1:0];
      end
    end
    return r;
  endfunction

  always_comb begin
    own = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) begin
        own = IW'(i);
      end
    end
  end

  assign pick   = rr_pick(req_valid, rr_q);
  assign nxt_rr = (own == IW'(NUM_REQ-1)) ? '0 : own + IW'(1);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    last_d  = last_q;
    ready_d = '0;
    data_d  = data_q;
    send_d  = 1'b0;
    err_d   = 1'b0;
`ifdef TX_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (grant_q == '0) begin
          if (|req_valid) begin
            grant_d       = '0;
            grant_d[pick] = 1'b1;
          end
        end else if (req_valid[own] && !tx_busy) begin
          ready_d[own] = 1'b1;
          data_d       = req_data[{own, 3'b000} +: 8];
          last_d       = req_last[own];
          state_d      = SEND;
        end
      end
      SEND: begin
        send_d  = 1'b1;
        state_d = WAIT_ACK;
`ifdef TX_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      WAIT_ACK: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
`ifdef TX_ARB_TIMEOUT_EN
        end else if (cnt_q == CW'(TIMEOUT_CYCLES-1)) begin
          // Transmitter never took the byte: drop it, end the packet.
          err_d   = 1'b1;
          grant_d = '0;
          rr_d    = nxt_rr;
          state_d = IDLE;
        end else begin
          cnt_d   = cnt_q + CW'(1);
`endif
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          state_d = IDLE;
          if (last_q) begin
            grant_d = '0;
            rr_d    = nxt_rr;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      last_q  <= 1'b0;
      ready_q <= '0;
      data_q  <= 8'h00;
      send_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      last_q  <= last_d;
      ready_q <= ready_d;
      data_q  <= data_d;
      send_q  <= send_d;
      err_q   <= err_d;
    end
  end

`ifdef TX_ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  assign req_ready = ready_q;
  assign grant     = grant_q;
  assign tx_data   = data_q;
  assign tx_send   = send_q;
  assign tx_err    = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: vector table, directed packet sequences,
// randomized traffic against a packet-level round-robin model.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int TO = 16;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   grant;
  logic [7:0]     tx_data;
  logic           tx_send;
  logic           tx_busy;
  logic           tx_err;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ(N),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_last(req_last),
    .req_ready(req_ready),
    .grant(grant),
    .tx_data(tx_data),
    .tx_send(tx_send),
    .tx_busy(tx_busy),
    .tx_err(tx_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic [3:0]  v;
    logic [3:0]  l;
    logic [31:0] d;
    logic        b;
    logic [3:0]  eg;
    logic [3:0]  er;
    logic        es;
    logic [7:0]  ed;
  } vec_t;

  typedef struct {
    int         r;
    logic [7:0] d;
  } exp_t;

  logic [8:0] rq [N][$];
  exp_t       exp_q[$];
  int         obs_q[$];
  logic       mid_pkt [N];
  int         model_rr = 0;
  int         bmode = 0;
  int         dmin = 1, dmax = 1, hmin = 1, hmax = 4;
  bit         gap_en = 0;
  int         pend = 0, hold = 0;
  int         n_acc = 0, n_send = 0, n_rdy = 0;

  task automatic step();
    logic [N-1:0] acc;
    logic         pb, prst, psend, ok;
    logic [7:0]   pdata;
    logic [8:0]   f;
    exp_t         e;
    acc   = req_valid & req_ready;
    pb    = tx_busy;
    prst  = reset;
    psend = tx_send;
    pdata = tx_data;
    @(posedge clk);
    #1;
    ok = 1'b1;
    if (!$onehot0(grant)) ok = 1'b0;
    if (!$onehot0(req_ready) || (req_ready & ~grant) != '0) ok = 1'b0;
    if (req_ready != '0 && pb) ok = 1'b0;
    if (!prst && tx_data !== pdata && req_ready == '0) ok = 1'b0;
    if (psend && tx_send) ok = 1'b0;
    if (bmode == 0 && tx_err) ok = 1'b0;
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL invariant: grant=%b ready=%b send=%b data=%h err=%b busy_before=%b",
               grant, req_ready, tx_send, tx_data, tx_err, pb);
    end
    if (req_ready != '0) n_rdy++;
    n_acc += $countones(acc);
    if (tx_send && !prst) begin
      n_send++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected send: data=%h grant=%b, expected none",
                 tx_data, grant);
      end else begin
        e = exp_q.pop_front();
        obs_q.push_back(e.r);
        chk("send data", 32'(tx_data), 32'(e.d));
        chk("send grant", 32'(grant), 32'(1) << e.r);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (acc[i] && rq[i].size() > 0) begin
        f = rq[i].pop_front();
        mid_pkt[i] = !f[8];
      end
    end
    if (bmode == 0) begin
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          tx_busy = 1'b1;
          hold = $urandom_range(hmin, hmax);
        end
      end else if (tx_busy) begin
        if (hold > 0) hold--;
        if (hold == 0) tx_busy = 1'b0;
      end
      if (tx_send) pend = $urandom_range(dmin, dmax);
    end else begin
      tx_busy = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      if (req_valid[i] && !acc[i] && rq[i].size() > 0) begin
        // holding an offered byte until it is accepted
      end else if (rq[i].size() > 0 &&
                   !(gap_en && mid_pkt[i] && $urandom_range(0, 2) == 0)) begin
        f = rq[i][0];
        req_valid[i]       = 1'b1;
        req_data[8*i +: 8] = f[7:0];
        req_last[i]        = f[8];
      end else begin
        req_valid[i]       = 1'b0;
        req_data[8*i +: 8] = 8'($urandom);
        req_last[i]        = 1'($urandom);
      end
    end
  endtask

  // Whole packets in round-robin order over requesters with data left.
  task automatic build_exp();
    int   pos [N];
    int   j;
    logic [8:0] b;
    exp_t e;
    for (int i = 0; i < N; i++) pos[i] = 0;
    forever begin
      j = -1;
      for (int k = 0; k < N; k++) begin
        if (j < 0 && pos[(model_rr + k) % N] < rq[(model_rr + k) % N].size())
          j = (model_rr + k) % N;
      end
      if (j < 0) break;
      do begin
        b = rq[j][pos[j]];
        pos[j]++;
        e.r = j;
        e.d = b[7:0];
        exp_q.push_back(e);
      end while (!b[8]);
      model_rr = (j + 1) % N;
    end
  endtask

  function automatic bit pending();
    bit p;
    p = exp_q.size() > 0 || grant != '0 || tx_busy;
    for (int i = 0; i < N; i++) if (rq[i].size() > 0) p = 1;
    return p;
  endfunction

  task automatic run_scen(input string nm, input int maxc, input bit build);
    int n;
    if (build) build_exp();
    n = 0;
    while (pending() && n < maxc) begin
      step();
      n++;
    end
    n_checks++;
    if (n >= maxc) begin
      n_errors++;
      $display("FAIL %s timeout: %0d cycles, expected < %0d", nm, n, maxc);
    end
    chk({nm, " drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    for (int i = 0; i < N; i++) begin
      rq[i].delete();
      mid_pkt[i] = 1'b0;
    end
    exp_q.delete();
    obs_q.delete();
    reset = 1'b1;
    req_valid = '0;
    tx_busy = 1'b0;
    pend = 0;
    hold = 0;
    step();
    step();
    chk("reset grant", 32'(grant), 32'd0);
    chk("reset ready", 32'(req_ready), 32'd0);
    chk("reset txdata", 32'(tx_data), 32'd0);
    chk("reset send/err", {30'd0, tx_send, tx_err}, 32'd0);
    reset = 1'b0;
    model_rr = 0;
  endtask

  function automatic int pack_obs();
    int r;
    r = 0;
    foreach (obs_q[k]) r = (r << 4) | obs_q[k];
    return r;
  endfunction

  task automatic gen_random();
    int np, nb;
    for (int i = 0; i < N; i++) begin
      np = $urandom_range(0, 3);
      for (int p = 0; p < np; p++) begin
        nb = $urandom_range(1, 4);
        for (int b = 0; b < nb; b++)
          rq[i].push_back({b == nb - 1, 8'($urandom)});
      end
    end
  endtask

  vec_t tv [21];

  initial begin
    int c0, k;
    bit seen;
    reset = 1'b1;
    req_valid = '0;
    req_last = '0;
    req_data = '0;
    tx_busy = 1'b0;
    for (int i = 0; i < N; i++) mid_pkt[i] = 1'b0;

    tv[0]  = '{1, 4'h0, 4'h0, 32'h0,        0, 4'h0, 4'h0, 0, 8'h00};
    tv[1]  = '{0, 4'h2, 4'h2, 32'h0000_A500, 0, 4'h2, 4'h0, 0, 8'h00};
    tv[2]  = '{0, 4'h2, 4'h2, 32'h0000_A500, 0, 4'h2, 4'h2, 0, 8'hA5};
    tv[3]  = '{0, 4'h2, 4'h2, 32'h0000_A500, 0, 4'h2, 4'h0, 1, 8'hA5};
    tv[4]  = '{0, 4'h0, 4'h0, 32'h0,        1, 4'h2, 4'h0, 0, 8'hA5};
    tv[5]  = '{0, 4'h0, 4'h0, 32'h0,        1, 4'h2, 4'h0, 0, 8'hA5};
    tv[6]  = '{0, 4'h0, 4'h0, 32'h0,        0, 4'h0, 4'h0, 0, 8'hA5};
    tv[7]  = '{0, 4'h5, 4'h5, 32'h0022_0011, 0, 4'h4, 4'h0, 0, 8'hA5};
    tv[8]  = '{0, 4'h5, 4'h5, 32'h0022_0011, 0, 4'h4, 4'h4, 0, 8'h22};
    tv[9]  = '{0, 4'h5, 4'h5, 32'h0022_0011, 0, 4'h4, 4'h0, 1, 8'h22};
    tv[10] = '{0, 4'h1, 4'h1, 32'h0000_0011, 1, 4'h4, 4'h0, 0, 8'h22};
    tv[11] = '{0, 4'h1, 4'h1, 32'h0000_0011, 0, 4'h0, 4'h0, 0, 8'h22};
    tv[12] = '{0, 4'h1, 4'h1, 32'h0000_0011, 1, 4'h1, 4'h0, 0, 8'h22};
    tv[13] = '{0, 4'h1, 4'h1, 32'h0000_0011, 1, 4'h1, 4'h0, 0, 8'h22};
    tv[14] = '{0, 4'h1, 4'h1, 32'h0000_0011, 1, 4'h1, 4'h0, 0, 8'h22};
    tv[15] = '{0, 4'h1, 4'h1, 32'h0000_0011, 0, 4'h1, 4'h1, 0, 8'h11};
    tv[16] = '{0, 4'h1, 4'h1, 32'h0000_0011, 0, 4'h1, 4'h0, 1, 8'h11};
    tv[17] = '{0, 4'h0, 4'h0, 32'h0,        1, 4'h1, 4'h0, 0, 8'h11};
    tv[18] = '{1, 4'h0, 4'h0, 32'h0,        1, 4'h0, 4'h0, 0, 8'h00};
    tv[19] = '{0, 4'h2, 4'h2, 32'h0000_5A00, 0, 4'h2, 4'h0, 0, 8'h00};
    tv[20] = '{0, 4'h2, 4'h2, 32'h0000_5A00, 0, 4'h2, 4'h2, 0, 8'h5A};

    for (int i = 0; i < 21; i++) begin
      reset     = tv[i].rst;
      req_valid = tv[i].v;
      req_last  = tv[i].l;
      req_data  = tv[i].d;
      tx_busy   = tv[i].b;
      @(posedge clk);
      #1;
      chk($sformatf("row%0d grant", i), 32'(grant), 32'(tv[i].eg));
      chk($sformatf("row%0d ready", i), 32'(req_ready), 32'(tv[i].er));
      chk($sformatf("row%0d send", i), 32'(tx_send), 32'(tv[i].es));
      chk($sformatf("row%0d txdata", i), 32'(tx_data), 32'(tv[i].ed));
      chk($sformatf("row%0d err", i), 32'(tx_err), 32'd0);
    end

    // req0 3-byte packet while req2 waits
    do_reset();
    rq[0].push_back(9'h041);
    rq[0].push_back(9'h042);
    rq[0].push_back(9'h143);
    rq[2].push_back(9'h177);
    run_scen("pkt_lock", 300, 1);
    chk("pkt_lock count", 32'(obs_q.size()), 32'd4);
    chk("pkt_lock order", 32'(pack_obs()), 32'h0002);

    // all four valid, single-byte packets: 0,1,2,3 twice
    do_reset();
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < N; i++)
        rq[i].push_back({1'b1, 4'(i), 4'(p)});
    run_scen("rr_wrap", 500, 1);
    chk("rr_wrap count", 32'(obs_q.size()), 32'd8);
    chk("rr_wrap order", 32'(pack_obs()), 32'h0123_0123);

    // randomized traffic, busy 1 cycle after send, then random delays
    do_reset();
    n_acc = 0;
    n_send = 0;
    gap_en = 1;
    hmin = 1;
    hmax = 8;
    for (int ph = 0; ph < 2; ph++) begin
      dmin = 1;
      dmax = (ph == 0) ? 1 : 3;
      c0 = 0;
      while (c0 < 5000) begin
        gen_random();
        obs_q.delete();
        k = 0;
        build_exp();
        begin
          int n;
          n = 0;
          while (pending() && n < 3000) begin
            step();
            n++;
          end
          c0 += n + 1;
          n_checks++;
          if (n >= 3000) begin
            n_errors++;
            $display("FAIL random timeout: %0d cycles, expected < 3000", n);
            c0 = 5000;
          end
        end
        step();
      end
      chk("random drained", 32'(exp_q.size()), 32'd0);
    end
    chk("accepts vs sends", 32'(n_acc), 32'(n_send));
    gap_en = 0;

    // transmitter never raises busy
    do_reset();
    rq[1].push_back(9'h199);
    rq[2].push_back(9'h155);
    build_exp();
    bmode = 1;
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      step();
      if (tx_send) seen = 1;
    end
    chk("stuck first send", 32'(seen), 32'd1);
`ifdef TX_ARB_TIMEOUT_EN
    k = 0;
    while (!tx_err && k < 40) begin
      step();
      k++;
    end
    chk("timeout delay", 32'(k), 32'(TO));
    chk("timeout grant", 32'(grant), 32'd0);
    step();
    chk("timeout pulse", 32'(tx_err), 32'd0);
    bmode = 0;
    obs_q.delete();
    run_scen("after_timeout", 200, 0);
    chk("after_timeout order", 32'(pack_obs()), 32'h2);
`else
    n_rdy = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      chk("stuck err", 32'(tx_err), 32'd0);
    end
    chk("stuck grant", 32'(grant), 32'h2);
    chk("stuck ready", 32'(n_rdy), 32'd0);
    chk("stuck sends", 32'(exp_q.size()), 32'd1);
    bmode = 0;
    do_reset();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
